// File: rtl/mac_sched.sv
// mac_sched: shares one MAC between two burst requesters, one whole burst at a time, round-robin.
// Optional feature macro MAC_SCHED_COUNT_EN: report the per-burst sample count on res_count_o.

module mac_sched #(
  parameter int width_p     = 16,
  parameter int out_width_p = 32,
  parameter int cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid0_i,
  output logic                   ready0_o,
  input  logic [width_p-1:0]     a0_i,
  input  logic [width_p-1:0]     b0_i,
  input  logic                   last0_i,
  input  logic                   valid1_i,
  output logic                   ready1_o,
  input  logic [width_p-1:0]     a1_i,
  input  logic [width_p-1:0]     b1_i,
  input  logic                   last1_i,
  output logic                   mac_clear_o,
  output logic                   mac_valid_o,
  input  logic                   mac_ready_i,
  output logic [width_p-1:0]     mac_a_o,
  output logic [width_p-1:0]     mac_b_o,
  input  logic                   mac_valid_i,
  output logic                   mac_ready_o,
  input  logic [out_width_p-1:0] mac_data_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [out_width_p-1:0] res_data_o,
  output logic                   res_id_o,
  output logic [cnt_width_p-1:0] res_count_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_gnt;
  logic                   r_rr;
  logic [1:0]             r_out;
  logic [out_width_p-1:0] r_res;

  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic [width_p-1:0]     w_sel_a;
  logic [width_p-1:0]     w_sel_b;
  logic                   w_room;
  logic                   w_pick;
  logic                   w_in_hs;
  logic                   w_out_hs;

  // Mux of the granted requester's sample; r_rr names the requester favoured on a tie
  always_comb begin
    w_sel_valid = r_gnt ? valid1_i : valid0_i;
    w_sel_last  = r_gnt ? last1_i  : last0_i;
    w_sel_a     = r_gnt ? a1_i     : a0_i;
    w_sel_b     = r_gnt ? b1_i     : b0_i;
    w_room      = (r_out != 2'd3);
    w_pick      = (valid0_i & valid1_i) ? r_rr : valid1_i;
  end

  assign w_in_hs  = mac_valid_o & mac_ready_i;
  assign w_out_hs = mac_valid_i & mac_ready_o & (r_out != 2'd0);

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    mac_clear_o = 1'b0;
    mac_valid_o = 1'b0;
    mac_a_o     = {width_p{1'b0}};
    mac_b_o     = {width_p{1'b0}};
    mac_ready_o = 1'b0;
    ready0_o    = 1'b0;
    ready1_o    = 1'b0;
    res_valid_o = 1'b0;
    res_data_o  = {out_width_p{1'b0}};
    res_id_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid0_i | valid1_i) begin
          w_state_nxt = CLEAR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        mac_clear_o = 1'b1;
        w_state_nxt = STREAM;
      end
      STREAM: begin
        mac_valid_o = w_sel_valid & w_room;
        mac_a_o     = w_sel_a;
        mac_b_o     = w_sel_b;
        mac_ready_o = 1'b1;
        ready0_o    = ~r_gnt & mac_ready_i & w_room;
        ready1_o    = r_gnt & mac_ready_i & w_room;
        if (w_sel_valid & w_room & mac_ready_i & w_sel_last) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = STREAM;
        end
      end
      DRAIN: begin
        mac_ready_o = 1'b1;
        if (r_out == 2'd0) begin
          w_state_nxt = RESULT;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      RESULT: begin
        res_valid_o = 1'b1;
        res_data_o  = r_res;
        res_id_o    = r_gnt;
        if (res_ready_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESULT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && (valid0_i | valid1_i)) begin
        r_gnt <= w_pick;
      end
      if ((r_state == RESULT) && res_ready_i) begin
        r_rr <= ~r_gnt;
      end
    end
  end

  // Outstanding MAC operations; a stray mac_valid_i at zero never reaches w_out_hs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_out <= 2'd0;
    end else begin
      case ({w_in_hs, w_out_hs})
        2'b10:   r_out <= r_out + 2'd1;
        2'b01:   r_out <= r_out - 2'd1;
        default: r_out <= r_out;
      endcase
    end
  end

  // Latest running sum returned by the MAC
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_res <= {out_width_p{1'b0}};
    end else if (w_out_hs) begin
      r_res <= mac_data_i;
    end
  end

`ifdef MAC_SCHED_COUNT_EN
  logic [cnt_width_p-1:0] r_cnt;

  // Saturating sample counter for the burst in flight
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= {cnt_width_p{1'b0}};
    end else if (r_state == CLEAR) begin
      r_cnt <= {cnt_width_p{1'b0}};
    end else if (w_in_hs && (r_cnt != {cnt_width_p{1'b1}})) begin
      r_cnt <= r_cnt + {{(cnt_width_p-1){1'b0}}, 1'b1};
    end
  end

  assign res_count_o = (r_state == RESULT) ? r_cnt : {cnt_width_p{1'b0}};
`else
  assign res_count_o = {cnt_width_p{1'b0}};
`endif

endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched: table vectors, directed corner sequences and a randomized
// run scored against burst sums computed directly from the generated operands.

module tb_mac_sched;
  localparam int W  = 16;
  localparam int OW = 32;
  localparam int CW = 8;
`ifdef MAC_SCHED_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk_i;
  logic reset_i;
  logic vld[2];
  logic lst[2];
  logic [W-1:0] opa[2];
  logic [W-1:0] opb[2];
  logic ready0_o, ready1_o, mac_clear_o, mac_valid_o, mac_ready_i, mac_valid_i, mac_ready_o;
  logic [W-1:0] mac_a_o, mac_b_o;
  logic [OW-1:0] mac_data_i, res_data_o;
  logic res_valid_o, res_ready_i, res_id_o;
  logic [CW-1:0] res_count_o;

  mac_sched #(.width_p(W), .out_width_p(OW), .cnt_width_p(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .valid0_i(vld[0]), .ready0_o(ready0_o), .a0_i(opa[0]), .b0_i(opb[0]), .last0_i(lst[0]),
    .valid1_i(vld[1]), .ready1_o(ready1_o), .a1_i(opa[1]), .b1_i(opb[1]), .last1_i(lst[1]),
    .mac_clear_o(mac_clear_o), .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
    .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o),
    .mac_data_i(mac_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_id_o(res_id_o), .res_count_o(res_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic last; } smp_t;
  typedef struct { logic [OW-1:0] data; int cnt; } exp_t;
  typedef struct { logic [OW-1:0] sum; int due; } mq_t;
  typedef struct { int req; int n; logic [W-1:0] a; logic [W-1:0] b; logic [OW-1:0] exp_data; int exp_cnt; } vec_t;

  smp_t sq0[$];
  smp_t sq1[$];
  exp_t eq0[$];
  exp_t eq1[$];
  mq_t  mq[$];
  int   exp_ids[$];
  logic mid[2];
  logic [OW-1:0] acc;
  int n_checks, n_fail, cyc, n_clear, n_res, n_acc, clr_cyc;
  logic clr_seen, err_inj;
  int mac_rdy_pct, res_rdy_pct, drop_pct;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [OW-1:0] sa, sb;
    sa = OW'($signed(a));
    sb = OW'($signed(b));
    return sa * sb;
  endfunction

  // Queue n samples for requester r; returns the 16.16 dot product of what was queued
  function automatic logic [OW-1:0] push_samples(input int r, input int n, input bit rnd,
                                                 input logic [W-1:0] fa, input logic [W-1:0] fb);
    smp_t s;
    logic [OW-1:0] sum;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      s.a = rnd ? W'($urandom) : fa;
      s.b = rnd ? W'($urandom) : fb;
      s.last = (i == n - 1);
      sum = sum + prod(s.a, s.b);
      if (r == 0) sq0.push_back(s); else sq1.push_back(s);
    end
    return sum;
  endfunction

  function automatic void push_exp(input int r, input logic [OW-1:0] data, input int cnt);
    exp_t e;
    e.data = data;
    e.cnt  = CNT_ON ? cnt : 0;
    if (r == 0) eq0.push_back(e); else eq1.push_back(e);
    exp_ids.push_back(r);
  endfunction

  task automatic clear_model();
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete(); mq.delete(); exp_ids.delete();
    mid[0] = 1'b0; mid[1] = 1'b0; acc = '0; clr_seen = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0; mac_valid_i = 1'b0;
  endtask

  task automatic check_zero();
    chk("rst_ready0", ready0_o, 1'b0);
    chk("rst_ready1", ready1_o, 1'b0);
    chk("rst_mac_clear", mac_clear_o, 1'b0);
    chk("rst_mac_valid", mac_valid_o, 1'b0);
    chk("rst_mac_ready", mac_ready_o, 1'b0);
    chk("rst_mac_a", mac_a_o, '0);
    chk("rst_mac_b", mac_b_o, '0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_res_data", res_data_o, '0);
    chk("rst_res_id", res_id_o, 1'b0);
    chk("rst_res_count", res_count_o, '0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    #1 check_zero();
    clear_model();
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  // One clock: drive requesters and the MAC model, then score what the DUT shows
  task automatic step();
    smp_t s;
    exp_t e;
    logic ih, rh0, rh1, pop;
    logic [1:0] exp_pair;
    int own;
    @(negedge clk_i);
    vld[0] = (sq0.size() > 0) && !(mid[0] && ($urandom_range(99) < drop_pct));
    vld[1] = (sq1.size() > 0) && !(mid[1] && ($urandom_range(99) < drop_pct));
    opa[0] = (sq0.size() > 0) ? sq0[0].a : W'($urandom);
    opb[0] = (sq0.size() > 0) ? sq0[0].b : W'($urandom);
    lst[0] = (sq0.size() > 0) ? sq0[0].last : 1'b0;
    opa[1] = (sq1.size() > 0) ? sq1[0].a : W'($urandom);
    opb[1] = (sq1.size() > 0) ? sq1[0].b : W'($urandom);
    lst[1] = (sq1.size() > 0) ? sq1[0].last : 1'b0;
    mac_ready_i = ($urandom_range(99) < mac_rdy_pct);
    res_ready_i = ($urandom_range(99) < res_rdy_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mac_valid_i = 1'b1; mac_data_i = mq[0].sum;
    end else if (err_inj && mq.size() == 0) begin
      mac_valid_i = 1'b1; mac_data_i = 32'hDEAD_BEEF;
    end else begin
      mac_valid_i = 1'b0; mac_data_i = $urandom;
    end
    #1;
    own = (exp_ids.size() > 0) ? exp_ids[0] : -1;
    chk("ready0_ungranted", ready0_o & (own != 0), 1'b0);
    chk("ready1_ungranted", ready1_o & (own != 1), 1'b0);
    chk("valid_gate_at_3", mac_valid_o & (mq.size() >= 3), 1'b0);
    rh0 = vld[0] & ready0_o;
    rh1 = vld[1] & ready1_o;
    ih  = mac_valid_o & mac_ready_i;
    if (ih | rh0 | rh1) begin
      exp_pair = ih ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("req_mac_handshake_pair", {rh1, rh0}, exp_pair);
    end
    if (mac_clear_o) begin
      acc = '0; n_clear++; clr_seen = 1'b1; clr_cyc = cyc;
      chk("clear_with_outstanding", mq.size(), 0);
    end
    pop = mac_valid_i & mac_ready_o & (mq.size() > 0);
    if (pop) mq.pop_front();
    if (ih) begin
      if (own < 0 || (own == 0 && sq0.size() == 0) || (own == 1 && sq1.size() == 0)) begin
        chk("mac_hs_without_sample", 1'b1, 1'b0);
      end else begin
        s = (own == 0) ? sq0[0] : sq1[0];
        chk("mac_a", mac_a_o, s.a);
        chk("mac_b", mac_b_o, s.b);
        if (!mid[own]) begin
          chk("clear_precedes_first_sample", clr_seen & (cyc > clr_cyc), 1'b1);
          clr_seen = 1'b0;
        end
        acc = acc + prod(s.a, s.b);
        mq.push_back('{acc, cyc + int'($urandom_range(4, 1))});
        mid[own] = !s.last;
        n_acc++;
        if (own == 0) sq0.pop_front(); else sq1.pop_front();
      end
    end
    chk("outstanding_max", mq.size() <= 3, 1'b1);
    if (res_valid_o) begin
      if (res_id_o ? (eq1.size() == 0) : (eq0.size() == 0)) begin
        chk("res_valid_unexpected", res_valid_o, 1'b0);
      end else begin
        e = res_id_o ? eq1[0] : eq0[0];
        chk("res_data", res_data_o, e.data);
        chk("res_count", res_count_o, e.cnt);
        chk("res_id", res_id_o, own);
        if (res_ready_i) begin
          if (res_id_o) eq1.pop_front(); else eq0.pop_front();
          exp_ids.pop_front();
          n_res++;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int k;
    k = 0;
    while ((sq0.size() + sq1.size() + eq0.size() + eq1.size() + mq.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    chk("run_complete_in_budget", k < budget, 1'b1);
  endtask

  initial begin
    int c0, r0, k;
    n_checks = 0; n_fail = 0; cyc = 0; n_clear = 0; n_res = 0; n_acc = 0; clr_cyc = -1;
    err_inj = 1'b0; mac_rdy_pct = 100; res_rdy_pct = 100; drop_pct = 0;
    reset_i = 1'b0; mac_ready_i = 1'b0; res_ready_i = 1'b0; mac_data_i = '0;
    opa[0] = '0; opb[0] = '0; lst[0] = 1'b0; opa[1] = '0; opb[1] = '0; lst[1] = 1'b0;
    clear_model();

    tbl[0] = '{0, 3,   16'h0100, 16'h0100, 32'h0003_0000, 3};
    tbl[1] = '{0, 1,   16'h0100, 16'h0100, 32'h0001_0000, 1};
    tbl[2] = '{1, 4,   16'h0080, 16'h0400, 32'h0008_0000, 4};
    tbl[3] = '{1, 2,   16'hFF00, 16'hFF00, 32'h0002_0000, 2};
    tbl[4] = '{0, 2,   16'h8000, 16'h0100, 32'hFF00_0000, 2};
    tbl[5] = '{1, 1,   16'h0300, 16'hFE00, 32'hFFFA_0000, 1};
    tbl[6] = '{0, 300, 16'h0001, 16'h0001, 32'h0000_012C, 255};

    #2 check_zero();
    @(negedge clk_i);
    reset_i = 1'b1;

    for (int i = 0; i < 7; i++) begin
      c0 = n_clear; r0 = n_res;
      void'(push_samples(tbl[i].req, tbl[i].n, 1'b0, tbl[i].a, tbl[i].b));
      push_exp(tbl[i].req, tbl[i].exp_data, tbl[i].exp_cnt);
      run_until_done(5000);
      chk("tbl_result_count", n_res - r0, 1);
      chk("tbl_clear_pulses", n_clear - c0, 1);
    end

    // both requesters contend straight out of reset: req0 first, then req1
    do_reset();
    void'(push_samples(0, 2, 1'b0, 16'h0200, 16'h0100));
    void'(push_samples(1, 2, 1'b0, 16'h0100, 16'hFF00));
    push_exp(0, 32'h0004_0000, 2);
    push_exp(1, 32'hFFFE_0000, 2);
    run_until_done(200);

    // back-to-back one-sample bursts from req0, each with its own clear
    c0 = n_clear; r0 = n_res;
    void'(push_samples(0, 1, 1'b0, 16'h0100, 16'h0100));
    void'(push_samples(0, 1, 1'b0, 16'h0100, 16'h0100));
    push_exp(0, 32'h0001_0000, 1);
    push_exp(0, 32'h0001_0000, 1);
    run_until_done(200);
    chk("b2b_clear_pulses", n_clear - c0, 2);
    chk("b2b_results", n_res - r0, 2);

    // stray mac_valid_i with nothing outstanding must be ignored
    void'(push_samples(0, 2, 1'b0, 16'h0100, 16'h0100));
    push_exp(0, 32'h0002_0000, 2);
    mac_rdy_pct = 0; err_inj = 1'b1;
    repeat (6) step();
    err_inj = 1'b0; mac_rdy_pct = 100;
    run_until_done(200);

    // reset after 2 of 4 samples: burst abandoned, next burst carries only its own sum
    do_reset();
    void'(push_samples(0, 4, 1'b0, 16'h0100, 16'h0100));
    push_exp(0, 32'h0004_0000, 4);
    n_acc = 0; k = 0;
    while (n_acc < 2 && k < 50) begin
      step();
      k++;
    end
    chk("mid_burst_samples", n_acc, 2);
    chk("mid_burst_mac_ready", mac_ready_o, 1'b1);
    r0 = n_res;
    do_reset();
    chk("abandoned_no_result", n_res - r0, 0);
    void'(push_samples(0, 2, 1'b0, 16'h0100, 16'h0100));
    push_exp(0, 32'h0002_0000, 2);
    run_until_done(200);
    chk("post_reset_result", n_res - r0, 1);

    // randomized: 25 bursts per requester, random backpressure and mid-burst valid drops
    do_reset();
    c0 = n_clear; r0 = n_res;
    mac_rdy_pct = 60; res_rdy_pct = 50; drop_pct = 20;
    for (int b = 0; b < 25; b++) begin
      int n0, n1;
      n0 = int'($urandom_range(6, 1));
      n1 = int'($urandom_range(6, 1));
      push_exp(0, push_samples(0, n0, 1'b1, '0, '0), n0);
      push_exp(1, push_samples(1, n1, 1'b1, '0, '0), n1);
    end
    run_until_done(30000);
    chk("rand_results", n_res - r0, 50);
    chk("rand_clears", n_clear - c0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
